// File: rtl/muldiv_ctrl.sv
// Sequencer between the EX stage and the shared multiplier / iterative divider:
// latches operands, drives the units, stalls the pipe and retires one HI/LO write.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stall_for_muldiv,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;
  typedef enum logic [2:0] {K_NONE, K_MULT, K_MULTU, K_DIV, K_DIVU} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d, kind_in;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        accept;

  // op is one-hot-ish {mult, multu, div, divu}; the leftmost set bit wins.
  always_comb begin
    if      (op[3]) kind_in = K_MULT;
    else if (op[2]) kind_in = K_MULTU;
    else if (op[1]) kind_in = K_DIV;
    else if (op[0]) kind_in = K_DIVU;
    else            kind_in = K_NONE;
  end

  assign accept = !rst && (state_q == IDLE) && op_valid && (kind_in != K_NONE) && !flush;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d          = state_q;
    kind_d           = kind_q;
    cnt_d            = cnt_q;
    op1_d            = op1_q;
    op2_d            = op2_q;
    hi_d             = hi_q;
    lo_d             = lo_q;
    mul_signed       = 1'b0;
    mul_ina          = '0;
    mul_inb          = '0;
    div_start        = 1'b0;
    div_signed       = 1'b0;
    div_opdata1      = '0;
    div_opdata2      = '0;
    div_annul        = 1'b0;
    stall_for_muldiv = 1'b0;
    hilo_we          = 1'b0;
    hi_wdata         = '0;
    lo_wdata         = '0;
    busy             = 1'b0;

    // Outputs are forced quiet while rst is high, whatever state is still registered.
    if (!rst) begin
      busy = (state_q != IDLE);
      if (state_q == IDLE) begin
        mul_signed = (kind_in == K_MULT);
        mul_ina    = src1;
        mul_inb    = src2;
      end else begin
        mul_signed = (kind_q == K_MULT);
        mul_ina    = op1_q;
        mul_inb    = op2_q;
      end

      unique case (state_q)
        IDLE: begin
          stall_for_muldiv = accept;
          if (accept) begin
            kind_d = kind_in;
            op1_d  = src1;
            op2_d  = src2;
            if (kind_in == K_MULT || kind_in == K_MULTU) begin
              cnt_d   = 4'(MUL_LAT - 1);
              state_d = MUL_WAIT;
            end else if (src2 != '0) begin
              state_d = DIV_WAIT;
            end else begin
              // Divide by zero never reaches the divider: HI gets the dividend.
              hi_d    = src1;
              lo_d    = '0;
              state_d = DONE;
            end
          end
        end

        MUL_WAIT: begin
          stall_for_muldiv = 1'b1;
          if (flush) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            hi_d    = mul_result[63:32];
            lo_d    = mul_result[31:0];
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end

        DIV_WAIT: begin
          stall_for_muldiv = 1'b1;
          div_signed       = (kind_q == K_DIV);
          div_opdata1      = op1_q;
          div_opdata2      = op2_q;
          if (flush) begin
            div_annul = 1'b1;
            state_d   = IDLE;
          end else if (div_ready) begin
            hi_d    = div_result[63:32];
            lo_d    = div_result[31:0];
            state_d = DONE;
          end else begin
            div_start = 1'b1;
          end
        end

        DONE: begin
          hilo_we  = 1'b1;
          hi_wdata = hi_q;
          lo_wdata = lo_q;
          if (flush || !hold) state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= K_NONE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier and divider models;
// expected HI/LO writes are queued at issue and popped by a write monitor.
module tb_muldiv_ctrl;

  localparam int unsigned MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, flush, hold, op_valid;
  logic [3:0]  op;
  logic [31:0] src1, src2;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul, div_ready;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result;
  logic        stall_for_muldiv, hilo_we, busy;
  logic [31:0] hi_wdata, lo_wdata;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .op_valid(op_valid), .op(op), .src1(src1), .src2(src2),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed),
    .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .stall_for_muldiv(stall_for_muldiv), .hilo_we(hilo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .busy(busy)
  );

  // Two-stage multiplier model: product valid MUL_LAT cycles after operands.
  logic [63:0] mp1, mp2, mprod;
  always_comb begin
    if (mul_signed) mprod = $signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb});
    else            mprod = {32'd0, mul_ina} * {32'd0, mul_inb};
  end
  always @(posedge clk) begin
    mp1 <= mprod;
    mp2 <= mp1;
  end
  assign mul_result = mp2;

  // Divider model: ready on the 34th consecutive cycle of div_start.
  logic [5:0] dcnt;
  assign div_ready = (dcnt == 6'd33);
  always @(posedge clk) begin
    if (rst || !div_start) dcnt <= '0;
    else                   dcnt <= dcnt + 6'd1;
  end
  always_comb begin
    if (div_opdata2 == '0) div_result = '0;
    else if (div_signed)   div_result = {$signed(div_opdata1) % $signed(div_opdata2),
                                         $signed(div_opdata1) / $signed(div_opdata2)};
    else                   div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } wr_t;
  wr_t exp_q[$];

  // Monitor: a write is consumed when it is presented with no hold and no flush.
  always @(negedge clk) begin
    if (!rst && hilo_we && !hold && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {63'd0, hilo_we}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("hi_wdata", {32'd0, hi_wdata}, {32'd0, e.hi});
        check("lo_wdata", {32'd0, lo_wdata}, {32'd0, e.lo});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l);
    wr_t e;
    e.hi = h;
    e.lo = l;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    logic start_ok;

    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    issue(4'b1000, 32'h1234_5678, 32'h9);
    repeat (2) cyc();
    smp();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_stall", {63'd0, stall_for_muldiv}, 64'd0);
    check("rst_mul_ina", {32'd0, mul_ina}, 64'd0);
    check("rst_hilo_we", {63'd0, hilo_we}, 64'd0);
    cyc();
    rst = 1'b0; op_valid = 1'b0; op = '0;

    // multu 0xFFFFFFFF * 2
    cyc();
    issue(4'b0100, 32'hFFFF_FFFF, 32'd2);
    push(32'h0000_0001, 32'hFFFF_FFFE);
    smp();
    check("mu_stall_T", {63'd0, stall_for_muldiv}, 64'd1);
    check("mu_signed", {63'd0, mul_signed}, 64'd0);
    check("mu_ina", {32'd0, mul_ina}, 64'h0000_0000_FFFF_FFFF);
    for (int i = 1; i <= 2; i++) begin
      cyc(); smp();
      check("mu_stall_wait", {62'd0, stall_for_muldiv, hilo_we}, 64'd2);
    end
    cyc(); smp();
    check("mu_done", {62'd0, stall_for_muldiv, hilo_we}, 64'd1);
    cyc();
    op_valid = 1'b0;
    smp();
    check("mu_after", {62'd0, busy, hilo_we}, 64'd0);

    // div -7 / 2, divider ready after 33 start cycles
    cyc();
    issue(4'b0010, 32'hFFFF_FFF9, 32'd2);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    smp();
    check("dv_stall_T", {62'd0, stall_for_muldiv, div_start}, 64'd2);
    n = 0;
    start_ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      cyc(); smp();
      if (hilo_we) begin
        n = i;
        break;
      end
      if (i == 1) begin
        check("dv_signed", {63'd0, div_signed}, 64'd1);
        check("dv_opdata", {div_opdata1, div_opdata2}, 64'hFFFF_FFF9_0000_0002);
      end
      if (div_start !== !div_ready || !stall_for_muldiv) start_ok = 1'b0;
    end
    check("dv_start_held", {63'd0, start_ok}, 64'd1);
    check("dv_latency", 64'(n), 64'd35);
    cyc();
    op_valid = 1'b0;
    smp();

    // divu 5 / 0: divider bypassed
    cyc();
    issue(4'b0001, 32'd5, 32'd0);
    push(32'h0000_0005, 32'h0);
    smp();
    check("dz_T", {61'd0, stall_for_muldiv, div_start, hilo_we}, 64'd4);
    cyc(); smp();
    check("dz_done", {61'd0, stall_for_muldiv, div_start, hilo_we}, 64'd1);
    cyc();
    op_valid = 1'b0;
    smp();

    // divu flushed in its 10th DIV_WAIT cycle
    cyc();
    issue(4'b0001, 32'd100, 32'd7);
    smp();
    for (int i = 1; i <= 9; i++) begin
      cyc(); smp();
    end
    cyc();
    flush = 1'b1;
    smp();
    check("fl_annul", {62'd0, div_annul, div_start}, 64'd2);
    cyc();
    flush = 1'b0; op_valid = 1'b0;
    smp();
    check("fl_idle", {60'd0, busy, stall_for_muldiv, div_annul, hilo_we}, 64'd0);

    // mult -3 * 4 with hold for 3 DONE cycles
    cyc();
    issue(4'b1000, 32'hFFFF_FFFD, 32'd4);
    push(32'hFFFF_FFFF, 32'hFFFF_FFF4);
    smp();
    check("hd_signed", {62'd0, mul_signed, stall_for_muldiv}, 64'd3);
    for (int i = 1; i <= 2; i++) begin
      cyc(); smp();
    end
    cyc();
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      smp();
      check("hd_we", {62'd0, hilo_we, stall_for_muldiv}, 64'd2);
      check("hd_data", {hi_wdata, lo_wdata}, 64'hFFFF_FFFF_FFFF_FFF4);
    end
    cyc();
    hold = 1'b0;
    smp();
    check("hd_release", {63'd0, hilo_we}, 64'd1);
    cyc();
    op_valid = 1'b0;
    smp();
    check("hd_idle", {62'd0, busy, hilo_we}, 64'd0);

    // multu and div both set: multu wins
    cyc();
    issue(4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'hFFFF_FFFE, 32'h0000_0001);
    smp();
    check("pr_sel", {61'd0, mul_signed, div_start, stall_for_muldiv}, 64'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc(); smp();
    end
    check("pr_done", {63'd0, hilo_we}, 64'd1);
    cyc();
    op_valid = 1'b0;
    smp();

    // flush in IDLE suppresses accept
    cyc();
    issue(4'b1000, 32'd1, 32'd2);
    flush = 1'b1;
    smp();
    check("fi_stall", {63'd0, stall_for_muldiv}, 64'd0);
    cyc();
    flush = 1'b0; op_valid = 1'b0;
    smp();
    check("fi_busy", {63'd0, busy}, 64'd0);

    // rst in MUL_WAIT with cnt=1
    cyc();
    issue(4'b1000, 32'd7, 32'd3);
    smp();
    cyc();
    rst = 1'b1;
    smp();
    check("rm_during", {62'd0, busy, stall_for_muldiv}, 64'd0);
    cyc();
    rst = 1'b0; op_valid = 1'b0; op = '0; src1 = '0; src2 = '0;
    smp();
    check("rm_ctrl", {59'd0, busy, stall_for_muldiv, hilo_we, div_start, mul_signed}, 64'd0);
    check("rm_mul", {mul_ina, mul_inb}, 64'd0);
    check("rm_hilo", {hi_wdata, lo_wdata}, 64'd0);
    check("rm_div", {div_opdata1, div_opdata2}, 64'd0);
    repeat (4) begin
      cyc(); smp();
    end
    check("rm_no_write", {63'd0, hilo_we}, 64'd0);

    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
